rgb_encoder_channel: RTL and testbench

Per-colour input stage of the RGB mixer: converts one rotary encoder's raw A/B pins into a saturating level register. The level register drives the downstream PWM generator. The top level instantiates three copies, one each for red, green and blue. Each copy synchronises and debounces the pins, decodes full quadrature cycles, and emits one-cycle step pulses for diagnostics.

---
 rtl/rgb_mixer_pkg.sv | 36 +++
 rtl/rgb_debounce.sv | 68 ++++++
 rtl/rgb_encoder_channel.sv | 160 ++++++++++++++++
 tb/tb_rgb_encoder_channel.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/rgb_mixer_pkg.sv
// RGB mixer shared types: quadrature states, encoder FSM states, constants.
// Used by rgb_debounce and rgb_encoder_channel (see RGB_ENC_DEBOUNCE_EN there).
package rgb_mixer_pkg;

  typedef enum logic [1:0] {
    Q00 = 2'b00,
    Q10 = 2'b10,
    Q11 = 2'b11,
    Q01 = 2'b01
  } quad_state_t;

  typedef enum logic {
    ARM = 1'b0,
    RUN = 1'b1
  } enc_state_t;

  localparam int ARM_CYCLES = 3;
  localparam int PHASE_FULL = 4;

  // Clockwise successor of a quadrature state.
  function automatic quad_state_t quad_next(
    input quad_state_t s
  );
    quad_state_t n;
    n = Q00;
    unique case (s)
      Q00: n = Q10;
      Q10: n = Q11;
      Q11: n = Q01;
      Q01: n = Q00;
      default: n = Q00;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rgb_debounce.sv
// Single-pin two-flop synchroniser plus stability filter.
// Filter exists only when RGB_ENC_DEBOUNCE_EN is defined.
module rgb_debounce
  import rgb_mixer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  input  logic load,
  output logic sync,
  output logic stable
);

  logic [1:0] sync_q;

  // Two-stage synchroniser for the asynchronous pin.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pin};
    end
  end

  assign sync = sync_q[1];

`ifdef RGB_ENC_DEBOUNCE_EN

  localparam logic [15:0] LIMIT =
    16'(DEBOUNCE_CYCLES);

  logic [15:0] cnt;
  logic        stable_q;

  // Accept a new level only after it has held long enough.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= 16'd0;
      stable_q <= 1'b0;
    end else if (load) begin
      cnt      <= 16'd0;
      stable_q <= sync;
    end else if (sync == stable_q) begin
      cnt <= 16'd0;
    end else if (cnt == LIMIT) begin
      cnt      <= 16'd0;
      stable_q <= sync;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  assign stable = stable_q;

`else

  logic        unused_load;
  logic [15:0] unused_cfg;

  assign unused_load = load;
  assign unused_cfg  = 16'(DEBOUNCE_CYCLES);
  assign stable      = sync;

`endif

endmodule

// File: rtl/rgb_encoder_channel.sv
// One colour channel: encoder pins -> quadrature decode -> saturating level.
// RGB_ENC_DEBOUNCE_EN enables the per-pin debounce filter.
module rgb_encoder_channel
  import rgb_mixer_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 255,
  parameter int STEP            = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             enc_a,
  input  logic             enc_b,
  output logic [WIDTH-1:0] level,
  output logic             step_up,
  output logic             step_down,
  output logic             enc_err
);

  localparam logic [1:0] ARM_LAST =
    2'(ARM_CYCLES - 1);
  localparam logic signed [3:0] FULL_P =
    4'(PHASE_FULL);
  localparam logic signed [3:0] FULL_N =
    -FULL_P;
  localparam logic [WIDTH:0] LVL_MAX =
    {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0] STEP_W =
    (WIDTH + 1)'(STEP);

  enc_state_t  state;
  logic [1:0]  arm_cnt;
  logic        arm_done;
  logic        load;
  logic        sync_a;
  logic        sync_b;
  logic        stable_a;
  logic        stable_b;
  quad_state_t cur;
  quad_state_t prev;
  logic signed [2:0] acc;
  logic signed [3:0] acc_nx;
  logic        moved;
  logic        fwd;
  logic        rev;
  logic        diag;
  logic        at_home;
  logic        det_up;
  logic        det_dn;
  logic [WIDTH:0]   lvl_up;
  logic [WIDTH:0]   lvl_dn;
  logic [WIDTH-1:0] up_sat;
  logic [WIDTH-1:0] dn_sat;

  assign arm_done = (arm_cnt == ARM_LAST);
  assign load     = (state == ARM) && arm_done;

  rgb_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_a (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (enc_a),
    .load  (load),
    .sync  (sync_a),
    .stable(stable_a)
  );

  rgb_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_b (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (enc_b),
    .load  (load),
    .sync  (sync_b),
    .stable(stable_b)
  );

  assign cur     = quad_state_t'({stable_a, stable_b});
  assign moved   = (cur != prev);
  assign diag    = ((cur ^ prev) == 2'b11);
  assign fwd     = moved && (cur == quad_next(prev));
  assign rev     = moved && (prev == quad_next(cur));
  assign at_home = (cur == Q00);

  // Phase count after this cycle's transition, one bit wider.
  always_comb begin
    acc_nx = {acc[2], acc};
    if (fwd) acc_nx = acc_nx + 4'sd1;
    if (rev) acc_nx = acc_nx - 4'sd1;
  end

  assign det_up = fwd && at_home && (acc_nx == FULL_P);
  assign det_dn = rev && at_home && (acc_nx == FULL_N);

  assign lvl_up = {1'b0, level} + STEP_W;
  assign lvl_dn = {1'b0, level} - STEP_W;
  assign up_sat = (lvl_up > LVL_MAX) ?
                  {WIDTH{1'b1}} : lvl_up[WIDTH-1:0];
  assign dn_sat = lvl_dn[WIDTH] ?
                  '0 : lvl_dn[WIDTH-1:0];

  // Arm sequencing, quadrature tracking, detent pulses and level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ARM;
      arm_cnt   <= 2'd0;
      prev      <= Q00;
      acc       <= 3'sd0;
      level     <= '0;
      step_up   <= 1'b0;
      step_down <= 1'b0;
      enc_err   <= 1'b0;
    end else begin
      step_up   <= 1'b0;
      step_down <= 1'b0;
      enc_err   <= 1'b0;
      unique case (state)
        ARM: begin
          if (arm_done) begin
            state <= RUN;
            prev  <= quad_state_t'({sync_a, sync_b});
            acc   <= 3'sd0;
          end else begin
            arm_cnt <= arm_cnt + 2'd1;
          end
        end
        RUN: begin
          unique case (1'b1)
            diag: begin
              prev    <= cur;
              acc     <= 3'sd0;
              enc_err <= ena;
            end
            fwd, rev: begin
              prev <= cur;
              acc  <= at_home ? 3'sd0 : acc_nx[2:0];
              if (ena && det_up) begin
                step_up <= 1'b1;
                level   <= up_sat;
              end
              if (ena && det_dn) begin
                step_down <= 1'b1;
                level     <= dn_sat;
              end
            end
            default: begin
            end
          endcase
        end
        default: begin
          state <= ARM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_encoder_channel.sv
// Directed bench for rgb_encoder_channel, DEBOUNCE_CYCLES=4, WIDTH=8.
// Expectations hold with or without RGB_ENC_DEBOUNCE_EN.
module tb_rgb_encoder_channel;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       enc_a;
  logic       enc_b;
  logic [7:0] level;
  logic       step_up;
  logic       step_down;
  logic       enc_err;

  int n_total = 0;
  int n_pass  = 0;
  int up_cnt  = 0;
  int dn_cnt  = 0;
  int err_cnt = 0;
  int wide_cnt = 0;
  int excl_cnt = 0;
  logic up_q  = 1'b0;
  logic dn_q  = 1'b0;
  logic err_q = 1'b0;
  int b_up;
  int b_dn;
  int b_err;

  rgb_encoder_channel #(
    .WIDTH(8),
    .DEBOUNCE_CYCLES(4),
    .STEP(1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .enc_a    (enc_a),
    .enc_b    (enc_b),
    .level    (level),
    .step_up  (step_up),
    .step_down(step_down),
    .enc_err  (enc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counting and shape checks, sampled on the falling edge.
  always @(negedge clk) begin
    if (step_up === 1'b1) up_cnt <= up_cnt + 1;
    if (step_down === 1'b1) dn_cnt <= dn_cnt + 1;
    if (enc_err === 1'b1) err_cnt <= err_cnt + 1;
    if ((step_up && up_q) || (step_down && dn_q) ||
        (enc_err && err_q))
      wide_cnt <= wide_cnt + 1;
    if ((step_up && step_down) ||
        (enc_err && (step_up || step_down)))
      excl_cnt <= excl_cnt + 1;
    up_q  <= step_up;
    dn_q  <= step_down;
    err_q <= enc_err;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d",
                tag, obs, exp);
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ab(input logic a, input logic b,
                        input int n);
    enc_a = a;
    enc_b = b;
    hold(n);
  endtask

  task automatic fwd_cycle();
    set_ab(1'b1, 1'b0, 20);
    set_ab(1'b1, 1'b1, 20);
    set_ab(1'b0, 1'b1, 20);
    set_ab(1'b0, 1'b0, 20);
  endtask

  task automatic rev_cycle();
    set_ab(1'b0, 1'b1, 20);
    set_ab(1'b1, 1'b1, 20);
    set_ab(1'b1, 1'b0, 20);
    set_ab(1'b0, 1'b0, 20);
  endtask

  task automatic mark();
    hold(1);
    b_up  = up_cnt;
    b_dn  = dn_cnt;
    b_err = err_cnt;
  endtask

  initial begin
    rst_n = 1'b0;
    ena   = 1'b1;
    enc_a = 1'b1;
    enc_b = 1'b1;
    hold(3);
    check("rst_level", level, 0);
    check("rst_up", step_up, 0);
    check("rst_down", step_down, 0);
    check("rst_err", enc_err, 0);

    rst_n = 1'b1;
    mark();
    hold(100);
    check("arm11_level", level, 0);
    check("arm11_pulses", up_cnt + dn_cnt - b_up - b_dn, 0);
    check("arm11_err", err_cnt - b_err, 0);

    mark();
    set_ab(1'b0, 1'b1, 20);
    set_ab(1'b0, 1'b0, 20);
    check("partial_pulses", up_cnt + dn_cnt - b_up - b_dn, 0);
    check("partial_level", level, 0);

    mark();
    repeat (3) fwd_cycle();
    check("fwd3_up", up_cnt - b_up, 3);
    check("fwd3_level", level, 3);

    mark();
    repeat (2) rev_cycle();
    check("rev2_down", dn_cnt - b_dn, 2);
    check("rev2_level", level, 1);

    mark();
    repeat (2) rev_cycle();
    check("sat0_down", dn_cnt - b_dn, 2);
    check("sat0_level", level, 0);

    mark();
    repeat (254) fwd_cycle();
    check("to254_level", level, 254);
    repeat (2) fwd_cycle();
    check("sat255_up", up_cnt - b_up, 256);
    check("sat255_level", level, 255);

    mark();
    set_ab(1'b1, 1'b0, 20);
    set_ab(1'b1, 1'b1, 20);
    set_ab(1'b1, 1'b0, 20);
    set_ab(1'b0, 1'b0, 20);
    check("half_pulses", up_cnt + dn_cnt - b_up - b_dn, 0);
    check("half_level", level, 255);

    mark();
    enc_a = 1'b1;
    hold(2);
    enc_a = 1'b0;
    hold(40);
    check("glitch_pulses", up_cnt + dn_cnt - b_up - b_dn, 0);
    check("glitch_err", err_cnt - b_err, 0);
    check("glitch_level", level, 255);

    rev_cycle();
    check("rev_level", level, 254);

    mark();
    set_ab(1'b1, 1'b1, 20);
    check("jump_err", err_cnt - b_err, 1);
    check("jump_level", level, 254);
    set_ab(1'b0, 1'b1, 20);
    set_ab(1'b0, 1'b0, 20);
    check("jump_ret_up", up_cnt - b_up, 0);
    fwd_cycle();
    check("after_jump_up", up_cnt - b_up, 1);
    check("after_jump_level", level, 255);
    check("after_jump_err", err_cnt - b_err, 1);

    mark();
    ena = 1'b0;
    rev_cycle();
    check("ena0_level", level, 255);
    check("ena0_pulses", up_cnt + dn_cnt - b_up - b_dn, 0);

    ena = 1'b1;
    set_ab(1'b1, 1'b0, 20);
    rst_n = 1'b0;
    hold(1);
    check("midrst_level", level, 0);
    rst_n = 1'b1;
    mark();
    set_ab(1'b1, 1'b1, 20);
    set_ab(1'b0, 1'b1, 20);
    set_ab(1'b0, 1'b0, 20);
    check("postrst_pulses", up_cnt + dn_cnt - b_up - b_dn, 0);
    check("postrst_err", err_cnt - b_err, 0);
    check("postrst_level", level, 0);
    fwd_cycle();
    check("postrst_up", up_cnt - b_up, 1);
    check("postrst_fwd_level", level, 1);

    hold(2);
    check("pulse_width", wide_cnt, 0);
    check("pulse_exclusive", excl_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
